// File: rtl/d8_alu_exec_pkg.sv
// d8_alu_exec_pkg: opcode codes and FSM state encoding shared by the ALU execute slice.
package d8_alu_exec_pkg;
    localparam logic [2:0] D8_ALU_PASS = 3'b000;
    localparam logic [2:0] D8_ALU_ADD  = 3'b001;
    localparam logic [2:0] D8_ALU_SUB  = 3'b010;
    localparam logic [2:0] D8_ALU_AND  = 3'b011;
    localparam logic [2:0] D8_ALU_OR   = 3'b100;
    localparam logic [2:0] D8_ALU_MUL  = 3'b101;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/d8_alu_exec_if.sv
// d8_alu_exec_if: request/result handshake bundle between decode, the ALU and write-back.
interface d8_alu_exec_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ctrl_alu;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_c;
    modport master (output in_valid, ctrl_alu, a, b, out_ready,
                    input  in_ready, out_valid, result, flag_z, flag_c);
    modport slave  (input  in_valid, ctrl_alu, a, b, out_ready,
                    output in_ready, out_valid, result, flag_z, flag_c);
endinterface

// File: rtl/d8_alu_exec_mul.sv
// d8_alu_mul: iterative shift-add unsigned multiplier, one partial product per cycle.
module d8_alu_mul #(parameter int WIDTH = 8) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic [WIDTH:0]     sum;
    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d = {sum, prod_q[WIDTH-1:1]};
    end
    assign done_o = busy_q && cnt_q == CW'(WIDTH - 1);
    assign busy_o = busy_q;
    assign prod_o = prod_d;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q  <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            prod_q  <= {{WIDTH{1'b0}}, b_i};
            mcand_q <= a_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            prod_q  <= prod_d;
            cnt_q   <= cnt_q + 1'b1;
            busy_q  <= !done_o;
        end
    end
endmodule

// File: rtl/d8_alu_exec.sv
// d8_alu_exec: handshaked ALU execute stage with registered result and z/c flags.
// Defining D8_ALU_MUL_EN turns code 101 into a WIDTH-cycle unsigned multiply.
module d8_alu_exec
    import d8_alu_exec_pkg::*;
#(parameter int WIDTH = 8) (
    input logic           sys_clk,
    input logic           sys_rst,
    d8_alu_exec_if.slave  alu
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d, alu_r;
    logic               z_q, z_d, c_q, c_d, alu_c;
    logic [WIDTH:0]     sum, diff;
    logic               accept, is_mul, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
`ifdef D8_ALU_MUL_EN
    assign is_mul = alu.ctrl_alu == D8_ALU_MUL;
    d8_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .start_i (accept && is_mul),
        .a_i     (alu.a),
        .b_i     (alu.b),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif
    assign alu.in_ready = !mul_busy && (state_q == ST_IDLE || (state_q == ST_DONE && alu.out_ready));
    assign accept       = alu.in_valid && alu.in_ready;
    always_comb begin
        sum   = {1'b0, alu.a} + {1'b0, alu.b};
        diff  = {1'b0, alu.a} - {1'b0, alu.b};
        alu_r = alu.ctrl_alu == D8_ALU_ADD ? sum[WIDTH-1:0] :
                alu.ctrl_alu == D8_ALU_SUB ? diff[WIDTH-1:0] :
                alu.ctrl_alu == D8_ALU_AND ? alu.a & alu.b :
                alu.ctrl_alu == D8_ALU_OR  ? alu.a | alu.b : alu.b;
        // The extra top bit of the difference is the unsigned borrow.
        alu_c = alu.ctrl_alu == D8_ALU_ADD ? sum[WIDTH] :
                alu.ctrl_alu == D8_ALU_SUB ? diff[WIDTH] : 1'b0;
    end
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        if (accept && !is_mul) begin
            state_d  = ST_DONE;
            result_d = alu_r;
            z_d      = alu_r == '0;
            c_d      = alu_c;
        end else if (accept) begin
            state_d = ST_MUL;
        end else if (state_q == ST_MUL && mul_done) begin
            state_d  = ST_DONE;
            result_d = mul_prod[WIDTH-1:0];
            z_d      = mul_prod[WIDTH-1:0] == '0;
            c_d      = |mul_prod[2*WIDTH-1:WIDTH];
        end else if (state_q == ST_DONE && alu.out_ready) begin
            state_d = ST_IDLE;
        end
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
        end
    end
    assign alu.out_valid = state_q == ST_DONE;
    assign alu.result    = result_q;
    assign alu.flag_z    = z_q;
    assign alu.flag_c    = c_q;
endmodule

// File: tb/tb_d8_alu_exec.sv
// tb_d8_alu_exec: directed and randomized check of d8_alu_exec against a transaction-level model.
// Honours D8_ALU_MUL_EN the same way the design does.
module tb_d8_alu_exec;
    localparam int W = 8;
    localparam int M = 1 << W;
`ifdef D8_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    d8_alu_exec_if #(.WIDTH(W)) bus ();
    d8_alu_exec #(.WIDTH(W)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .alu(bus.slave));
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result/carry and latency of one operation, straight from the opcode table.
    task automatic model(input int code, input int x, input int y, output int r, output int c, output int lat);
        lat = 1;
        c   = 0;
        r   = y;
        case (code)
            1: begin r = (x + y) % M; c = int'((x + y) >= M); end
            2: begin r = (x - y + M) % M; c = int'(x < y); end
            3: r = x & y;
            4: r = x | y;
            5: if (MUL_EN) begin r = (x * y) % M; c = int'((x * y) >= M); lat = W + 1; end
            default: r = y;
        endcase
    endtask

    bit m_valid = 1'b0;
    bit exp_rdy;
    int m_cnt = 0, m_r = 0, m_c = 0, p_r = 0, p_c = 0, p_lat = 0;

    // Model: a result appears lat cycles after accept and is held until consumed.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_r     = p_r;
                    m_c     = p_c;
                end
            end
            exp_rdy = m_cnt == 0 && (!m_valid || bus.out_ready);
            chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("result", 32'(bus.result), m_r);
                chk("flag_z", 32'(bus.flag_z), 32'(m_r == 0));
                chk("flag_c", 32'(bus.flag_c), m_c);
            end
            chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            if (m_valid && bus.out_ready) m_valid = 1'b0;
            if (bus.in_valid && exp_rdy) begin
                model(int'(bus.ctrl_alu), int'(bus.a), int'(bus.b), p_r, p_c, p_lat);
                m_cnt = p_lat;
            end
        end
    end

    task automatic issue(input logic [2:0] code, input logic [7:0] x, input logic [7:0] y);
        int n;
        bus.in_valid = 1'b1;
        bus.ctrl_alu = code;
        bus.a        = x;
        bus.b        = y;
        n = 0;
        @(negedge sys_clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge sys_clk);
        end
        if (n >= 50) chk("issue_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge sys_clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge sys_clk);
            cyc++;
        end while (!bus.out_valid && cyc < 40);
    endtask

    int lat;

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.ctrl_alu  = 3'd0;
        bus.a         = '0;
        bus.b         = '0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags", {30'd0, bus.flag_z, bus.flag_c}, 32'd0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        issue(3'd1, 8'hF0, 8'h20);
        @(negedge sys_clk);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_res", 32'(bus.result), 32'h10);
        chk("add_zc", {30'd0, bus.flag_z, bus.flag_c}, 32'b01);

        issue(3'd2, 8'h05, 8'h05);
        bus.in_valid = 1'b1;
        bus.ctrl_alu = 3'd2;
        bus.a        = 8'h03;
        bus.b        = 8'h04;
        @(negedge sys_clk);
        chk("sub0_res", 32'(bus.result), 32'h00);
        chk("sub0_zc", {30'd0, bus.flag_z, bus.flag_c}, 32'b10);
        chk("sub0_ready", 32'(bus.in_ready), 32'd1);
        @(posedge sys_clk);
        #1 bus.in_valid = 1'b0;
        @(negedge sys_clk);
        chk("sub1_valid", 32'(bus.out_valid), 32'd1);
        chk("sub1_res", 32'(bus.result), 32'hFF);
        chk("sub1_zc", {30'd0, bus.flag_z, bus.flag_c}, 32'b01);
        @(posedge sys_clk);
        #1;

        bus.out_ready = 1'b0;
        issue(3'd3, 8'h0F, 8'hF0);
        repeat (3) begin
            @(negedge sys_clk);
            chk("and_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("and_hold_res", 32'(bus.result), 32'h00);
            chk("and_hold_z", 32'(bus.flag_z), 32'd1);
            chk("and_hold_ready", 32'(bus.in_ready), 32'd0);
            @(posedge sys_clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge sys_clk);
        chk("and_take_ready", 32'(bus.in_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("and_drained", 32'(bus.out_valid), 32'd0);

        issue(3'd5, 8'h10, 8'h11);
        wait_valid(lat);
        chk("mul_latency", lat, MUL_EN ? W + 1 : 1);
        chk("mul_res", 32'(bus.result), MUL_EN ? 32'h10 : 32'h11);
        chk("mul_c", 32'(bus.flag_c), MUL_EN ? 32'd1 : 32'd0);
        @(posedge sys_clk);
        #1;
        issue(3'd5, 8'h03, 8'h05);
        wait_valid(lat);
        chk("mul2_res", 32'(bus.result), MUL_EN ? 32'h0F : 32'h05);
        chk("mul2_c", 32'(bus.flag_c), 32'd0);
        @(posedge sys_clk);
        #1;

        for (int k = 6; k < 8; k++) begin
            issue(3'(k), 8'($urandom), 8'hA5);
            @(negedge sys_clk);
            chk("pass_res", 32'(bus.result), 32'hA5);
            chk("pass_zc", {30'd0, bus.flag_z, bus.flag_c}, 32'b00);
        end

        issue(3'd1, 8'h40, 8'h01);
        issue(3'd5, 8'h03, 8'h05);
        repeat (3) @(posedge sys_clk);
        #3 sys_rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", 32'(bus.result), 32'd0);
        chk("midrst_flags", {30'd0, bus.flag_z, bus.flag_c}, 32'd0);
        chk("midrst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        issue(3'd1, 8'h01, 8'h01);
        @(negedge sys_clk);
        chk("postrst_add", 32'(bus.result), 32'h02);
        chk("postrst_valid", 32'(bus.out_valid), 32'd1);

        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.ctrl_alu  = 3'($urandom_range(0, 7));
            bus.a         = $urandom_range(0, 4) == 0 ? 8'hFF : 8'($urandom);
            bus.b         = $urandom_range(0, 4) == 0 ? 8'h00 : 8'($urandom);
            bus.out_ready = $urandom_range(0, 3) != 0;
            @(posedge sys_clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(posedge sys_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
